transpose_stream_buffer: RTL and testbench

//   Streaming, sequential counterpart of the combinational matrix transpose.
//   - Accepts an INPUT_SIZE_1 x INPUT_SIZE_2 matrix one element per beat, in row-major order.
//   - Emits the transposed matrix (INPUT_SIZE_2 x INPUT_SIZE_1) one element per beat, also
//     row-major, i.e. input column-major order.
//   - Ping-pong (two-bank) storage lets one matrix drain while the next one fills.
//   - Sits between streaming producers/consumers where the flattened full-width bus is too wide.

---
 rtl/transpose_stream_buffer.sv | 109 ++++++++++
 tb/tb_transpose_stream_buffer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/transpose_stream_buffer.sv
// Streaming matrix transpose: accepts an M x N matrix row-major, emits it column-major.
// Two banks ping-pong so one matrix can drain while the next one fills.
module transpose_stream_buffer #(
  parameter int INPUT_SIZE_1 = 4,
  parameter int INPUT_SIZE_2 = 3,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_last
);

  localparam int M     = INPUT_SIZE_1;
  localparam int N     = INPUT_SIZE_2;
  localparam int DEPTH = M * N;
  localparam int IW    = (M > 1) ? $clog2(M) : 1;
  localparam int JW    = (N > 1) ? $clog2(N) : 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [IW-1:0] I_LAST = IW'(M - 1);
  localparam logic [JW-1:0] J_LAST = JW'(N - 1);

  logic signed [DATA_WIDTH-1:0] mem [2][DEPTH];

  logic [1:0]    full;
  logic          wr_bank, rd_bank;
  logic [IW-1:0] wr_i, rd_i;
  logic [JW-1:0] wr_j, rd_j;
  logic [AW-1:0] wr_addr, rd_addr;
  logic          in_hs, out_hs, wr_done, rd_done;
  logic [1:0]    set_full, clr_full;

  assign wr_addr = AW'(int'(wr_i) * N + int'(wr_j));
  assign rd_addr = AW'(int'(rd_i) * N + int'(rd_j));

  assign in_ready  = !full[wr_bank];
  assign in_hs     = in_valid && in_ready;
  assign wr_done   = in_hs && (wr_i == I_LAST) && (wr_j == J_LAST);

  assign out_valid = full[rd_bank];
  assign out_data  = out_valid ? mem[rd_bank][rd_addr] : '0;
  assign out_last  = out_valid && (rd_i == I_LAST) && (rd_j == J_LAST);
  assign out_hs    = out_valid && out_ready;
  assign rd_done   = out_hs && out_last;

  // A completing write and a completing read always target different banks,
  // so both flag updates can apply in the same cycle without conflict.
  assign set_full = {wr_done && wr_bank, wr_done && !wr_bank};
  assign clr_full = {rd_done && rd_bank, rd_done && !rd_bank};

  // NOTE: storage has no reset; the full flags alone decide whether contents are live.
  always_ff @(posedge clk) begin
    if (in_hs) mem[wr_bank][wr_addr] <= in_data;
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank <= 1'b0;
      wr_i    <= '0;
      wr_j    <= '0;
    end else if (in_hs) begin
      if (wr_j == J_LAST) begin
        wr_j <= '0;
        if (wr_i == I_LAST) begin
          wr_i    <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_i <= wr_i + IW'(1);
        end
      end else begin
        wr_j <= wr_j + JW'(1);
      end
    end
  end

  // Read side walks rows fastest, which yields the column-major (transposed) order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bank <= 1'b0;
      rd_i    <= '0;
      rd_j    <= '0;
    end else if (out_hs) begin
      if (rd_i == I_LAST) begin
        rd_i <= '0;
        if (rd_j == J_LAST) begin
          rd_j    <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          rd_j <= rd_j + JW'(1);
        end
      end else begin
        rd_i <= rd_i + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) full <= 2'b00;
    else     full <= (full | set_full) & ~clr_full;
  end

endmodule

// File: tb/tb_transpose_stream_buffer.sv
// Bench for transpose_stream_buffer: queue-based transpose model checked every cycle,
// plus directed literal expectations and a degenerate 1x5 instance.
module tb_transpose_stream_buffer;

  localparam int M     = 4;
  localparam int N     = 3;
  localparam int DW    = 8;
  localparam int DEPTH = M * N;
  localparam int DN    = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                 in_valid, in_ready, out_valid, out_ready, out_last;
  logic signed [DW-1:0] in_data, out_data;

  logic                 d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_out_last;
  logic signed [DW-1:0] d_in_data, d_out_data;

  transpose_stream_buffer #(.INPUT_SIZE_1(M), .INPUT_SIZE_2(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  transpose_stream_buffer #(.INPUT_SIZE_1(1), .INPUT_SIZE_2(DN), .DATA_WIDTH(DW)) dut_deg (
    .clk(clk), .rst(rst),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data), .out_last(d_out_last)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int data;
    bit last;
  } beat_t;

  beat_t exp_q[$];
  int    cur[$];
  int    src_q[$];
  bit    m_in_hs   = 1'b0;
  int    valid_pct = 0;
  int    ready_pct = 0;

  // Each pending matrix occupies one bank until its last beat leaves.
  function automatic bit model_ready();
    return ((exp_q.size() + DEPTH - 1) / DEPTH) < 2;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      cur.delete();
      m_in_hs = 1'b0;
    end else begin
      bit ihs, ohs;
      beat_t b;
      ihs = in_valid && model_ready();
      ohs = out_ready && (exp_q.size() > 0);
      m_in_hs = ihs;
      if (ohs) void'(exp_q.pop_front());
      if (ihs) begin
        cur.push_back(int'(in_data));
        if (cur.size() == DEPTH) begin
          for (int k = 0; k < DEPTH; k++) begin
            b.data = cur[(k % M) * N + k / M];
            b.last = (k == DEPTH - 1);
            exp_q.push_back(b);
          end
          cur.delete();
        end
      end
    end
  end

  // Source driver: presents the head of src_q with random valid, random out_ready.
  always begin
    @(posedge clk);
    #1;
    if (m_in_hs && src_q.size() > 0) void'(src_q.pop_front());
    in_valid  = (src_q.size() > 0) && ($urandom_range(99) < valid_pct);
    if (src_q.size() > 0) in_data = DW'(src_q[0]);
    else                  in_data = '0;
    out_ready = $urandom_range(99) < ready_pct;
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_data", $signed(out_data), 0);
    end else begin
      check("out_valid", out_valid, exp_q.size() > 0);
      check("in_ready", in_ready, model_ready());
      if (exp_q.size() > 0) begin
        check("out_data", $signed(out_data), exp_q[0].data);
        check("out_last", out_last, exp_q[0].last);
      end else begin
        check("idle_out_data", $signed(out_data), 0);
        check("idle_out_last", out_last, 0);
      end
    end
  end

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (src_q.size() == 0 && exp_q.size() == 0 && cur.size() == 0) done = 1'b1;
    end
    check("idle_timeout", done, 1);
  endtask

  task automatic push_range(input int first, input int count);
    for (int k = 0; k < count; k++) src_q.push_back(first + k);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int got[$];
    int gl[$];
    int t1_exp[DEPTH] = '{0, 3, 6, 9, 1, 4, 7, 10, 2, 5, 8, 11};
    int stalls, gaps, acc, hs, n;
    bit fin, lat_pending, rose;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    d_in_valid = 1'b0; d_in_data = '0; d_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1 check("in_ready_after_rst", in_ready, 1);

    // 1. single matrix, latency and literal order
    push_range(0, DEPTH);
    valid_pct = 100; ready_pct = 100;
    fin = 1'b0; lat_pending = 1'b0;
    for (int c = 0; c < 100 && got.size() < DEPTH; c++) begin
      @(negedge clk);
      if (lat_pending) begin
        check("t1_latency_valid", out_valid, 1);
        lat_pending = 1'b0;
      end
      if (!fin && in_valid && in_ready && src_q.size() == 1) begin
        fin = 1'b1;
        lat_pending = 1'b1;
        check("t1_no_early_valid", out_valid, 0);
      end
      if (out_valid && out_ready) begin
        got.push_back($signed(out_data));
        gl.push_back(out_last);
      end
    end
    check("t1_count", got.size(), DEPTH);
    for (int k = 0; k < got.size(); k++) begin
      check("t1_data", got[k], t1_exp[k]);
      check("t1_last", gl[k], k == DEPTH - 1);
    end
    wait_idle(100);

    // 2. back-to-back matrices, no stalls and no output gaps
    got.delete(); gl.delete();
    push_range(0, DEPTH);
    push_range(100, DEPTH);
    stalls = 0; gaps = 0;
    for (int c = 0; c < 200 && got.size() < 2 * DEPTH; c++) begin
      @(negedge clk);
      if (src_q.size() > 0 && !in_ready) stalls++;
      if (got.size() > 0 && !out_valid) gaps++;
      if (out_valid && out_ready) begin
        got.push_back($signed(out_data));
        gl.push_back(out_last);
      end
    end
    check("t2_count", got.size(), 2 * DEPTH);
    check("t2_stalls", stalls, 0);
    check("t2_gaps", gaps, 0);
    if (got.size() == 2 * DEPTH) begin
      check("t2_m2_first", got[DEPTH], 100);
      check("t2_m2_second", got[DEPTH + 1], 103);
      check("t2_m2_final", got[2 * DEPTH - 1], 111);
      check("t2_m2_last", gl[2 * DEPTH - 1], 1);
      check("t2_m1_last", gl[DEPTH - 1], 1);
    end
    wait_idle(100);

    // 3. backpressure with three matrices offered
    ready_pct = 0;
    push_range(0, 3 * DEPTH);
    acc = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (in_valid && in_ready) acc++;
    end
    check("t3_accepted", acc, 2 * DEPTH);
    check("t3_in_ready_low", in_ready, 0);
    check("t3_hold_valid", out_valid, 1);
    check("t3_hold_data", $signed(out_data), 0);
    ready_pct = 100;
    hs = 0; rose = 1'b0;
    for (int c = 0; c < 50 && !rose; c++) begin
      @(negedge clk);
      if (in_ready) rose = 1'b1;
      else if (out_valid && out_ready) hs++;
    end
    check("t3_ready_rose", rose, 1);
    check("t3_handshakes_before_ready", hs, DEPTH);
    wait_idle(300);

    // 4. random stalls over 50 signed matrices
    for (int m = 0; m < 50; m++)
      for (int k = 0; k < DEPTH; k++) begin
        if (m == 0 && k == 0)      src_q.push_back(-128);
        else if (m == 0 && k == 1) src_q.push_back(127);
        else                       src_q.push_back(int'($urandom_range(255)) - 128);
      end
    valid_pct = 70; ready_pct = 60;
    n = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) n++;
      if (src_q.size() == 0 && exp_q.size() == 0 && cur.size() == 0) break;
    end
    check("t4_beats", n, 50 * DEPTH);
    wait_idle(10);

    // 5. reset after the 5th output beat
    valid_pct = 100; ready_pct = 100;
    push_range(0, DEPTH);
    n = 0;
    for (int c = 0; c < 100 && n < 5; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) n++;
    end
    check("t5_reached_5", n, 5);
    @(posedge clk);
    #2;
    valid_pct = 0;
    src_q.delete();
    rst = 1'b1;
    #1;
    check("t5_rst_out_valid", out_valid, 0);
    check("t5_rst_out_data", $signed(out_data), 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("t5_in_ready", in_ready, 1);
    check("t5_out_valid", out_valid, 0);
    got.delete();
    valid_pct = 100;
    push_range(50, DEPTH);
    for (int c = 0; c < 100 && got.size() < 1; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) got.push_back($signed(out_data));
    end
    check("t5_first_count", got.size(), 1);
    if (got.size() == 1) check("t5_first_elem", got[0], 50);
    wait_idle(100);
    valid_pct = 0; ready_pct = 0;

    // 6. degenerate 1x5 instance: order unchanged
    @(posedge clk);
    #1;
    check("t6_in_ready", d_in_ready, 1);
    for (int i = 1; i <= DN; i++) begin
      d_in_valid = 1'b1;
      d_in_data  = DW'(i);
      @(posedge clk);
      #1;
    end
    d_in_valid = 1'b0;
    check("t6_latency_valid", d_out_valid, 1);
    for (int k = 0; k < DN; k++) begin
      @(negedge clk);
      check("t6_valid", d_out_valid, 1);
      check("t6_data", $signed(d_out_data), k + 1);
      check("t6_last", d_out_last, k == DN - 1);
    end
    @(negedge clk);
    check("t6_drained", d_out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
